snax_tcdm_responder: RTL and testbench



---
 rtl/snax_tcdm_responder_pkg.sv | 70 +++++++
 rtl/snax_rr_arbiter.sv | 41 ++++
 rtl/snax_tcdm_responder.sv | 142 ++++++++++++++
 tb/tb_snax_tcdm_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_tcdm_responder_pkg.sv
// Shared types and helpers for the banked TCDM responder model.
// Holds the default geometry, the request/response structs, address mapping and strobe merge.
package snax_tcdm_responder_pkg;

  localparam int TcdmNumPorts  = 4;
  localparam int TcdmNumBanks  = 8;
  localparam int TcdmDataWidth = 64;
  localparam int TcdmAddrWidth = 48;
  localparam int TcdmBankDepth = 256;
  localparam int TcdmStrbWidth = TcdmDataWidth / 8;
  localparam int TcdmAmoWidth  = 4;
  localparam int TcdmUserWidth = 1;

  localparam int ByteOffWidth = $clog2(TcdmStrbWidth);
  localparam int BankIdxWidth = $clog2(TcdmNumBanks);
  localparam int RowIdxWidth  = $clog2(TcdmBankDepth);

  typedef struct packed {
    logic [TcdmAddrWidth-1:0] addr;
    logic                     write;
    logic [TcdmAmoWidth-1:0]  amo;
    logic [TcdmDataWidth-1:0] data;
    logic [TcdmStrbWidth-1:0] strb;
    logic [TcdmUserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    tcdm_rsp_chan_t p;
    logic           p_valid;
    logic           q_ready;
  } tcdm_rsp_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] row;
  } bank_row_t;

  // Word-interleaved mapping; address bits above bank+row are dropped so rows wrap.
  function automatic bank_row_t addr_map(input logic [TcdmAddrWidth-1:0] addr,
                                         input int unsigned off_w,
                                         input int unsigned bank_w,
                                         input int unsigned row_w);
    logic [TcdmAddrWidth-1:0] word;
    bank_row_t r;
    word   = addr >> off_w;
    r.bank = 32'(word & ((TcdmAddrWidth'(1) << bank_w) - TcdmAddrWidth'(1)));
    r.row  = 32'((word >> bank_w) & ((TcdmAddrWidth'(1) << row_w) - TcdmAddrWidth'(1)));
    return r;
  endfunction

  function automatic logic [TcdmDataWidth-1:0] strb_merge(input logic [TcdmDataWidth-1:0] old_w,
                                                          input logic [TcdmDataWidth-1:0] new_w,
                                                          input logic [TcdmStrbWidth-1:0] strb);
    logic [TcdmDataWidth-1:0] res;
    for (int b = 0; b < TcdmStrbWidth; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/snax_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past the winner.
module snax_rr_arbiter #(
  parameter int NumPorts = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o
);

  localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d, sel;
  logic            found;
  int              idx;

  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    idx   = 0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = (int'(rr_ptr_q) + i) % NumPorts;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = PtrW'(idx);
      end
    end
    gnt_o    = '0;
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      gnt_o[sel] = 1'b1;
      rr_ptr_d   = (int'(sel) == NumPorts - 1) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/snax_tcdm_responder.sv
// Banked, word-interleaved TCDM memory answering SNAX tcdm requests.
// One port per bank per cycle, round-robin; read data returns one cycle after grant.
module snax_tcdm_responder
  import snax_tcdm_responder_pkg::*;
#(
  parameter int NumPorts      = TcdmNumPorts,
  parameter int NumBanks      = TcdmNumBanks,
  parameter int DataWidth     = TcdmDataWidth,
  parameter int TCDMAddrWidth = TcdmAddrWidth,
  parameter int BankDepth     = TcdmBankDepth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  tcdm_req_t [NumPorts-1:0]   tcdm_req_i,
  output tcdm_rsp_t [NumPorts-1:0]   tcdm_rsp_o,
  output logic [31:0]                conflict_cnt_o
);

  localparam int OffW  = $clog2(DataWidth / 8);
  localparam int BankW = $clog2(NumBanks);
  localparam int RowW  = $clog2(BankDepth);

  logic [DataWidth-1:0] mem_q [NumBanks][BankDepth];

  logic [NumPorts-1:0][BankW-1:0]    port_bank;
  logic [NumPorts-1:0][RowW-1:0]     port_row;
  logic [NumBanks-1:0][NumPorts-1:0] bank_req, bank_gnt;
  logic [NumPorts-1:0]               gnt;
  logic                              unused_fields;

  logic [NumBanks-1:0]                bank_we;
  logic [NumBanks-1:0][RowW-1:0]      bank_row;
  logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;

  logic [NumPorts-1:0]                rsp_vld_q, rsp_vld_d;
  logic [NumPorts-1:0][DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic [31:0]                        conflict_cnt_q, conflict_cnt_d;

  // Decode every port and build per-bank request vectors; reset silences all requests.
  always_comb begin
    bank_row_t br;
    br            = '0;
    unused_fields = 1'b0;
    port_bank     = '0;
    port_row      = '0;
    bank_req      = '0;
    for (int p = 0; p < NumPorts; p++) begin
      br           = addr_map(tcdm_req_i[p].q.addr, OffW, BankW, RowW);
      port_bank[p] = br.bank[BankW-1:0];
      port_row[p]  = br.row[RowW-1:0];
      unused_fields = unused_fields ^ (^{tcdm_req_i[p].q.amo, tcdm_req_i[p].q.user,
                                         br.bank[31:BankW], br.row[31:RowW]});
      for (int b = 0; b < NumBanks; b++) begin
        bank_req[b][p] = tcdm_req_i[p].q_valid && !rst_i && (port_bank[p] == BankW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    snax_rr_arbiter #(
      .NumPorts(NumPorts)
    ) i_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < NumBanks; b++) gnt = gnt | bank_gnt[b];
  end

  // Write path: at most one granted port per bank, merged with the current row.
  always_comb begin
    bank_we    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[b][p] && tcdm_req_i[p].q.write) begin
          bank_we[b]    = 1'b1;
          bank_row[b]   = port_row[p];
          bank_wdata[b] = strb_merge(mem_q[b][port_row[p]], tcdm_req_i[p].q.data,
                                     tcdm_req_i[p].q.strb);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_we[b]) mem_q[b][bank_row[b]] <= bank_wdata[b];
    end
  end

  // Read path samples the row at the handshake edge; data holds between responses.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rsp_vld_d[p]  = gnt[p] && !tcdm_req_i[p].q.write;
      rsp_data_d[p] = rsp_vld_d[p] ? mem_q[port_bank[p]][port_row[p]] : rsp_data_q[p];
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (|(tcdm_req_valid() & ~gnt) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  function automatic logic [NumPorts-1:0] tcdm_req_valid();
    logic [NumPorts-1:0] v;
    for (int p = 0; p < NumPorts; p++) v[p] = tcdm_req_i[p].q_valid;
    return v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld_q      <= '0;
      rsp_data_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rsp_vld_q      <= rsp_vld_d;
      rsp_data_q     <= rsp_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  always_comb begin
    tcdm_rsp_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      tcdm_rsp_o[p].q_ready = gnt[p];
      tcdm_rsp_o[p].p_valid = rsp_vld_q[p] && !rst_i;
      tcdm_rsp_o[p].p.data  = rst_i ? '0 : rsp_data_q[p];
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Bench for snax_tcdm_responder: directed vector table, multi-cycle corner sequences,
// and random traffic checked cycle by cycle against a word-array reference model.
module tb_snax_tcdm_responder;
  import snax_tcdm_responder_pkg::*;

  localparam int NP = 4;
  localparam int NB = 8;
  localparam int BD = 256;
  localparam int NW = NB * BD;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  tcdm_req_t [NP-1:0]  req;
  tcdm_rsp_t [NP-1:0]  rsp;
  logic [31:0]         cnt;

  snax_tcdm_responder #(
    .NumPorts(NP), .NumBanks(NB), .DataWidth(64), .TCDMAddrWidth(48), .BankDepth(BD)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tcdm_req_i     (req),
    .tcdm_rsp_o     (rsp),
    .conflict_cnt_o (cnt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          vld;
    bit          wr;
    logic [47:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } preq_t;

  typedef struct {
    bit          wr;
    logic [47:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp;
  } vec_t;

  preq_t       cur     [NP];
  logic [63:0] m_mem   [NW];
  bit   [7:0]  m_kb    [NW];
  int          m_ptr   [NB];
  bit          m_pv    [NP];
  bit          m_pk    [NP];
  logic [63:0] m_pd    [NP];
  logic [31:0] m_cnt;
  bit          gnt_m   [NP];
  bit          dut_rdy [NP];
  int          nchk = 0;
  int          nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int bank_of(input logic [47:0] a);
    return int'((a / 48'd8) % 48'(NB));
  endfunction

  function automatic int widx(input logic [47:0] a);
    return int'((a / 48'd8) % 48'(NW));
  endfunction

  // One clock cycle: drive, compare against the model at negedge, advance the model.
  task automatic step(input bit rst);
    bit g [NP];
    bit anywait;
    int port, w;
    rst_i = rst;
    for (int p = 0; p < NP; p++) begin
      req[p]         = '0;
      req[p].q_valid = cur[p].vld;
      req[p].q.write = cur[p].wr;
      req[p].q.addr  = cur[p].addr;
      req[p].q.data  = cur[p].data;
      req[p].q.strb  = cur[p].strb;
      req[p].q.amo   = 4'($urandom);
      req[p].q.user  = 1'($urandom);
    end
    @(negedge clk_i);
    for (int p = 0; p < NP; p++) g[p] = 1'b0;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < NP; k++) begin
          port = (m_ptr[b] + k) % NP;
          if (cur[port].vld && bank_of(cur[port].addr) == b) begin
            g[port] = 1'b1;
            break;
          end
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      dut_rdy[p] = rsp[p].q_ready;
      chk($sformatf("q_ready[%0d]", p), 64'(rsp[p].q_ready), 64'(g[p]));
      chk($sformatf("p_valid[%0d]", p), 64'(rsp[p].p_valid), 64'(!rst && m_pv[p]));
      if (!rst && m_pv[p] && m_pk[p]) chk($sformatf("p_data[%0d]", p), rsp[p].p.data, m_pd[p]);
      if (rst) chk($sformatf("rst_p_data[%0d]", p), rsp[p].p.data, 64'd0);
    end
    chk("conflict_cnt", 64'(cnt), 64'(m_cnt));
    anywait = 1'b0;
    for (int p = 0; p < NP; p++) if (cur[p].vld && !g[p]) anywait = 1'b1;
    if (rst) begin
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
      for (int p = 0; p < NP; p++) m_pv[p] = 1'b0;
      m_cnt = 32'd0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        m_pv[p] = g[p] && !cur[p].wr;
        if (m_pv[p]) begin
          w       = widx(cur[p].addr);
          m_pd[p] = m_mem[w];
          m_pk[p] = (m_kb[w] == 8'hFF);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (g[p] && cur[p].wr) begin
          w = widx(cur[p].addr);
          for (int bb = 0; bb < 8; bb++) begin
            if (cur[p].strb[bb]) begin
              m_mem[w][8*bb +: 8] = cur[p].data[8*bb +: 8];
              m_kb[w][bb]         = 1'b1;
            end
          end
        end
        if (g[p]) m_ptr[bank_of(cur[p].addr)] = (p + 1) % NP;
      end
      if (anywait && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    for (int p = 0; p < NP; p++) gnt_m[p] = g[p];
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input bit wr, input logic [47:0] a, input logic [63:0] d,
                              input logic [7:0] s, input logic [63:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp = e;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [12];
    int   order [NP];
    int   done, cyc, w;
    int   wt [NP];
    logic [3:0] pv;
    logic [31:0] cnt_before;

    tv[0]  = mk(1, 48'h0,    64'h1122334455667788, 8'hFF, 64'h0);
    tv[1]  = mk(0, 48'h0,    64'h0,                8'h00, 64'h1122334455667788);
    tv[2]  = mk(1, 48'h8,    64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0);
    tv[3]  = mk(1, 48'h8,    64'h0,                8'h0F, 64'h0);
    tv[4]  = mk(0, 48'h8,    64'h0,                8'h00, 64'hFFFFFFFF00000000);
    tv[5]  = mk(0, 48'hC,    64'h0,                8'h00, 64'hFFFFFFFF00000000);
    tv[6]  = mk(1, 48'h10,   64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0);
    tv[7]  = mk(1, 48'h10,   64'h0123456789ABCDEF, 8'hA5, 64'h0);
    tv[8]  = mk(0, 48'h10,   64'h0,                8'h00, 64'h01AA45AAAAABAAEF);
    tv[9]  = mk(1, 48'h4000, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0);
    tv[10] = mk(0, 48'h0,    64'h0,                8'h00, 64'h5A5A5A5A5A5A5A5A);
    tv[11] = mk(0, 48'h4008, 64'h0,                8'h00, 64'hFFFFFFFF00000000);

    for (int i = 0; i < NW; i++) begin m_mem[i] = '0; m_kb[i] = '0; end
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < NP; p++) begin
      m_pv[p] = 0; m_pk[p] = 0; m_pd[p] = '0; cur[p].vld = 0; wt[p] = 0;
      cur[p].wr = 0; cur[p].addr = '0; cur[p].data = '0; cur[p].strb = '0;
    end
    m_cnt = '0;

    step(1);
    step(1);

    // Directed single-port vectors, back to back (read right after write included).
    for (int i = 0; i < 12; i++) begin
      cur[0].vld = 1; cur[0].wr = tv[i].wr; cur[0].addr = tv[i].addr;
      cur[0].data = tv[i].data; cur[0].strb = tv[i].strb;
      step(0);
      chk($sformatf("tv%0d_p_valid", i), 64'(rsp[0].p_valid), 64'(!tv[i].wr));
      if (!tv[i].wr) chk($sformatf("tv%0d_data", i), rsp[0].p.data, tv[i].exp);
      cur[0].vld = 0;
    end
    step(0);

    // Four distinct banks in one cycle.
    cnt_before = m_cnt;
    for (int p = 0; p < NP; p++) begin
      cur[p].vld = 1; cur[p].wr = 0; cur[p].addr = 48'(p * 8);
    end
    step(0);
    for (int p = 0; p < NP; p++) pv[p] = rsp[p].p_valid;
    chk("distinct_p_valid", 64'(pv), 64'hF);
    chk("distinct_cnt", 64'(cnt), 64'(cnt_before));
    for (int p = 0; p < NP; p++) cur[p].vld = 0;
    step(0);

    // Same-bank contention after reset: grants in port order, three conflict cycles.
    step(1);
    for (int p = 0; p < NP; p++) begin
      cur[p].vld = 1; cur[p].wr = 0; cur[p].addr = 48'h40;
    end
    done = 0; cyc = 0;
    while (done < NP && cyc < 8) begin
      step(0);
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (dut_rdy[p] && cur[p].vld) begin
          if (done < NP) order[done] = p;
          done++;
          cur[p].vld = 0;
        end
      end
    end
    for (int p = 0; p < NP; p++) cur[p].vld = 0;
    chk("arb_cycles", 64'(cyc), 64'd4);
    for (int i = 0; i < NP; i++) chk($sformatf("arb_order%0d", i), 64'(order[i]), 64'(i));
    chk("arb_conflict_cnt", 64'(cnt), 64'd3);

    // Reset in the cycle after a read grant drops the response, memory survives.
    cur[0].vld = 1; cur[0].wr = 0; cur[0].addr = 48'h0;
    step(0);
    cur[0].vld = 0;
    step(1);
    step(0);
    chk("rst_drop_p_valid", 64'(rsp[0].p_valid), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    cur[0].vld = 1;
    step(0);
    chk("rst_mem_keep", rsp[0].p.data, 64'h5A5A5A5A5A5A5A5A);
    cur[0].vld = 0;

    // Random traffic with hold-until-granted requesters.
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!cur[p].vld && ($urandom % 3 != 0)) begin
          w           = int'($urandom % 32);
          cur[p].vld  = 1;
          cur[p].wr   = 1'($urandom);
          cur[p].addr = 48'(w * 8) + 48'($urandom % 8) + 48'($urandom % 4) * 48'h4000;
          cur[p].data = {$urandom, $urandom};
          cur[p].strb = ($urandom % 4 == 0) ? 8'($urandom) : 8'hFF;
        end
      end
      if ($urandom % 100 == 0) begin
        step(1);
        for (int p = 0; p < NP; p++) wt[p] = 0;
      end else begin
        step(0);
        for (int p = 0; p < NP; p++) begin
          if (gnt_m[p]) begin
            chk("starve_bound", 64'(wt[p] < NP), 64'd1);
            cur[p].vld = 0;
            wt[p] = 0;
          end else if (cur[p].vld) begin
            wt[p]++;
          end
        end
      end
    end
    for (int p = 0; p < NP; p++) cur[p].vld = 0;
    step(0);
    step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
